// File: rtl/multi_digit_seven_seg.sv
// multi_digit_seven_seg
//   Time-multiplexed driver for NUM_DIGITS seven-segment digits that share one
//   segment bus. The caller loads a packed hex word and per-digit decimal points
//   into a shadow register. The shadow copy moves to the displayed (active) copy
//   only at a frame boundary, so a frame never mixes old and new digits. Each
//   digit is shown for SLOT_CYCLES clocks. The first GUARD_CYCLES of every slot
//   turn all digits off so the previous digit does not ghost onto the next one.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   value         hex digits, digit i = value[4i+3:4i], digit 0 least significant
//   dp_in         decimal point request per digit, 1 = lit
//   load          capture value/dp_in into the shadow register
//   blank_lz      1 = blank leading zero digits (sampled live)
//   display_segs  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
//   display_dp    decimal point of the digit currently shown
//   digit_en      one-hot digit select, polarity per ACTIVE_LOW
//   frame_done    one-cycle pulse after the last digit slot of a frame ends
module multi_digit_seven_seg #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              display_segs,
  output logic                    display_dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // POL is XORed onto the internal "1 = lit" signals to get pin polarity.
  localparam logic             POL       = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        slot_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] active_val;
  logic [NUM_DIGITS-1:0]   active_dp;

  logic                    slot_end;
  logic                    frame_end;
  logic                    in_guard;
  logic [3:0]              nib;
  logic                    dp_req;
  logic                    lead_zero;
  logic                    zero_run;
  logic [6:0]              segs_lit;
  logic                    dp_lit;
  logic [NUM_DIGITS-1:0]   en_lit;

  // Returns the segment pattern in active-low form {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (digit_idx == IDX_LAST);

  // Scan position: slot counter inside a digit, digit index across the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
    end
  end

  // The last load of a frame wins. A load that lands on the boundary cycle
  // itself bypasses the shadow so it is not delayed by a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      active_val <= '0;
      active_dp  <= '0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (frame_end) begin
        active_val <= load ? value : shadow_val;
        active_dp  <= load ? dp_in : shadow_dp;
      end
      frame_done <= frame_end;
    end
  end

  // Digit selection and leading-zero detection. zero_run stays high while
  // every nibble from the top down to the current index is zero.
  always_comb begin
    nib       = 4'h0;
    dp_req    = 1'b0;
    lead_zero = 1'b0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (active_val[4*i +: 4] == 4'h0);
      if (digit_idx == IDX_W'(i)) begin
        nib       = active_val[4*i +: 4];
        dp_req    = active_dp[i];
        lead_zero = zero_run && (i != 0);
      end
    end
  end

  always_comb begin
    in_guard = (slot_cnt < GUARD_END);
    segs_lit = '0;
    dp_lit   = 1'b0;
    en_lit   = '0;
    if (!in_guard) begin
      // A blanked leading zero still drives its digit and honours its dp.
      segs_lit = (blank_lz && lead_zero) ? 7'h00 : ~seg_decode(nib);
      dp_lit   = dp_req;
      en_lit   = NUM_DIGITS'(1) << digit_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_segs <= {7{POL}};
      display_dp   <= POL;
      digit_en     <= {NUM_DIGITS{POL}};
    end else begin
      display_segs <= segs_lit ^ {7{POL}};
      display_dp   <= dp_lit ^ POL;
      digit_en     <= en_lit ^ {NUM_DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_multi_digit_seven_seg.sv
module tb_multi_digit_seven_seg;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [6:0]  display_segs;
  logic        display_dp;
  logic [3:0]  digit_en;
  logic        frame_done;

  int n_vec;
  int n_miscmp;

  localparam logic [12:0] OFF_STATE = {7'h7F, 1'b1, 4'hF, 1'b0};

  multi_digit_seven_seg #(
    .NUM_DIGITS(4),
    .SLOT_CYCLES(8),
    .GUARD_CYCLES(2),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .dp_in(dp_in),
    .load(load),
    .blank_lz(blank_lz),
    .display_segs(display_segs),
    .display_dp(display_dp),
    .digit_en(digit_en),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {display_segs, display_dp, digit_en, frame_done};
  endfunction

  task automatic apply_load(input logic [15:0] v, input logic [3:0] dp);
    value = v;
    dp_in = dp;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load  = 1'b0;
  endtask

  // Advance to just after the edge on which frame_done is seen high.
  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) seen = 1'b1;
    end
    if (!seen) check_val({name, " frame_done timeout"}, 32'd0, 32'd1);
  endtask

  // Checks one whole frame, starting right after a boundary edge.
  // exp_segs = {digit3, digit2, digit1, digit0} in active-low form,
  // exp_dp   = active-low dp level per digit.
  task automatic check_frame(input string name, input logic [27:0] exp_segs, input logic [3:0] exp_dp);
    logic [12:0] e;
    logic [3:0]  en_exp;
    int c;
    int d;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #1;
      c = (k - 1) % 8;
      d = (k - 1) / 8;
      en_exp = ~(4'b0001 << d);
      if (c < 2) e = {7'h7F, 1'b1, 4'hF, 1'b0};
      else       e = {exp_segs[7*d +: 7], exp_dp[d], en_exp, 1'b0};
      e[0] = (k == 32);
      check_val($sformatf("%s k%0d", name, k), {19'd0, outs()}, {19'd0, e});
    end
  endtask

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    dp_in    = '0;
    blank_lz = 1'b0;

    #2;
    check_val("reset_off", {19'd0, outs()}, {19'd0, OFF_STATE});
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_held", {19'd0, outs()}, {19'd0, OFF_STATE});
    rst = 1'b0;

    apply_load(16'h12AF, 4'b0000);
    wait_frame("12AF");
    check_frame("12AF", {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'hF);

    blank_lz = 1'b1;
    apply_load(16'h0042, 4'b0000);
    wait_frame("0042");
    check_frame("0042_blank", {7'h7F, 7'h7F, 7'b0011001, 7'b0100100}, 4'hF);

    blank_lz = 1'b0;
    check_frame("0042_noblank", {7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100}, 4'hF);

    blank_lz = 1'b1;
    apply_load(16'h0402, 4'b0000);
    wait_frame("0402");
    check_frame("0402_blank", {7'h7F, 7'b0011001, 7'b1000000, 7'b0100100}, 4'hF);

    apply_load(16'h0000, 4'b0100);
    wait_frame("0000");
    check_frame("0000_dp2", {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1011);

    blank_lz = 1'b0;
    apply_load(16'h1111, 4'b0000);
    repeat (5) @(posedge clk);
    #1;
    apply_load(16'h2222, 4'b0000);
    wait_frame("2222");
    check_frame("2222_last_wins", {4{7'b0100100}}, 4'hF);

    repeat (31) @(posedge clk);
    #1;
    value = 16'h3859;
    dp_in = 4'b0000;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load  = 1'b0;
    check_val("bnd_pulse", {31'd0, frame_done}, 32'd1);
    check_frame("3859_bnd_load", {7'b0110000, 7'b0000000, 7'b0010010, 7'b0010000}, 4'hF);

    blank_lz = 1'b1;
    repeat (12) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_val("rst_async", {19'd0, outs()}, {19'd0, OFF_STATE});
    @(posedge clk);
    #1;
    check_val("rst_hold", {19'd0, outs()}, {19'd0, OFF_STATE});
    rst = 1'b0;
    check_frame("post_rst", {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
